// File: rtl/sort_floats_n_using_fsm_pkg.sv
// Shared float package: element width, legacy element count and the sorter
// FSM state type. Used by the N-element sorter, its interface and benches.
package sort_floats_n_using_fsm_pkg;

  // Width of one IEEE-754 double element.
  localparam int FLEN = 64;

  // Element count of the original fixed 3-element sorter.
  localparam int NE = 3;

  // IDLE waits for a request, SORT runs one compare per cycle,
  // DONE presents the result for a single cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_fsm_state_t;

endpackage

// File: rtl/sort_floats_n_using_fsm_if.sv
// Request/response bundle of the N-element float sorter.
//
// Handshake: the requester raises valid_in with descending/unsorted stable
// for one cycle; the sorter samples them only while busy is low, and ignores
// valid_in otherwise (no back-pressure, no queueing). The sorter answers with
// a single-cycle valid_out; sorted and err are meaningful only in that cycle.
interface sort_floats_n_using_fsm_if
  import sort_floats_n_using_fsm_pkg::*;
#(
  parameter int N   = 4,
  parameter int ELW = FLEN
);

  logic                    valid_in;
  logic                    descending;
  logic [0:N-1][ELW-1:0]   unsorted;
  logic                    valid_out;
  logic [0:N-1][ELW-1:0]   sorted;
  logic                    err;
  logic                    busy;

  // Requester side.
  modport master (
    output valid_in, descending, unsorted,
    input  valid_out, sorted, err, busy
  );

  // Sorter side.
  modport slave (
    input  valid_in, descending, unsorted,
    output valid_out, sorted, err, busy
  );

endinterface

// File: rtl/sort_floats_n_using_fsm.sv
// N-element floating-point bubble sorter that time-multiplexes one external
// combinational f_less_or_equal comparator (f_le_* ports), one compare per
// cycle. Ascending or descending order is chosen per request.
//
// Optional build macro SORT_EARLY_EXIT_EN: finish as soon as a full pass
// performs no swap (data-dependent latency, minimum N cycles). Without it the
// latency is a fixed (N-1)^2 + 1 cycles from acceptance to valid_out.
module sort_floats_n_using_fsm
  import sort_floats_n_using_fsm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sort_floats_n_using_fsm_if.slave bus,
  output logic [FLEN-1:0]          f_le_a,
  output logic [FLEN-1:0]          f_le_b,
  input  logic                     f_le_res,
  input  logic                     f_le_err,
  output sort_fsm_state_t          state_dbg
);

  localparam int             IW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  LAST = IW'(N - 2);

  sort_fsm_state_t           state_q, state_d;
  logic [0:N-1][FLEN-1:0]    buf_q, buf_d;
  logic [IW-1:0]             i_q, i_d;
  logic [IW-1:0]             p_q, p_d;
  logic                      desc_q, desc_d;
  logic                      err_q, err_d;
  logic [IW-1:0]             i_nx;
  logic                      do_swap;
`ifdef SORT_EARLY_EXIT_EN
  logic                      swapped_q, swapped_d;
`endif

  // Neighbour index of the current compare; never exceeds N-1.
  assign i_nx = i_q + 1'b1;

  // A swap is needed when the ordered pair (a, b) is not a <= b.
  assign do_swap = ~f_le_res;

  // Register all FSM and datapath state; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      i_q       <= '0;
      p_q       <= '0;
      desc_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      i_q       <= i_d;
      p_q       <= p_d;
      desc_q    <= desc_d;
      err_q     <= err_d;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  // Next-state, buffer update and comparator operand selection.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    i_d       = i_q;
    p_d       = p_q;
    desc_d    = desc_q;
    err_d     = err_q;
`ifdef SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    // Outside SORT the operands just mirror the first two buffer slots.
    f_le_a    = buf_q[0];
    f_le_b    = buf_q[1];

    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          buf_d     = bus.unsorted;
          desc_d    = bus.descending;
          i_d       = '0;
          p_d       = '0;
          err_d     = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          state_d   = SORT;
        end
      end

      SORT: begin
        // Descending order simply asks the comparator the mirrored question.
        if (desc_q) begin
          f_le_a = buf_q[i_nx];
          f_le_b = buf_q[i_q];
        end else begin
          f_le_a = buf_q[i_q];
          f_le_b = buf_q[i_nx];
        end

        if (f_le_err) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          // Equal elements report a <= b, so they stay put (stable sort).
          if (do_swap) begin
            buf_d[i_q]  = buf_q[i_nx];
            buf_d[i_nx] = buf_q[i_q];
`ifdef SORT_EARLY_EXIT_EN
            swapped_d   = 1'b1;
`endif
          end
          if (i_q == LAST) begin
            i_d = '0;
            p_d = p_q + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
            // A pass without any swap means the buffer is already ordered.
            if (!(swapped_q || do_swap)) begin
              state_d = DONE;
            end
`endif
            if (p_q == LAST) begin
              state_d = DONE;
            end
          end else begin
            i_d = i_nx;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.valid_out = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
  assign bus.sorted    = buf_q;
  assign state_dbg     = state_q;

endmodule
